// File: rtl/vga_scan_gen.sv
// 640x480@60Hz raster timing: clock divider, h/v scan counters, sync/blank/coord decode.
// Outputs are zero-latency decodes of the live counters; no backpressure, free-running.
module vga_scan_gen #(
   parameter int CLK_DIV   = 2,
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic       clock,
   input  logic       reset,
   output logic       HS,
   output logic       VS,
   output logic       blank,
   output logic [8:0] row,
   output logic [9:0] col,
   output logic       pix_tick,
   output logic       frame_start
);
   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

   // Decode bounds are 11 bits so a sync pulse ending exactly at 1024 still compares correctly.
   localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
   localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
   localparam logic [10:0] VS_BEG = 11'(V_VISIBLE + V_FRONT);
   localparam logic [10:0] VS_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [9:0]       h_cnt_q, h_cnt_d;
   logic [9:0]       v_cnt_q, v_cnt_d;
   logic [10:0]      h_ext, v_ext;

   // Gated by reset so a CLK_DIV=1 build does not strobe while held in reset.
   assign pix_tick = (div_cnt_q == DIV_LAST) && !reset;

   always_ff @(posedge clock) begin
      if (reset) begin
         div_cnt_q <= '0;
         h_cnt_q   <= '0;
         v_cnt_q   <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
         h_cnt_q   <= h_cnt_d;
         v_cnt_q   <= v_cnt_d;
      end
   end

   always_comb begin
      div_cnt_d = div_cnt_q + 1'b1;
      h_cnt_d   = h_cnt_q;
      v_cnt_d   = v_cnt_q;
      if (pix_tick) begin
         div_cnt_d = '0;
         if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
         end else begin
            h_cnt_d = h_cnt_q + 10'd1;
         end
      end
   end

   always_comb begin
      h_ext       = {1'b0, h_cnt_q};
      v_ext       = {1'b0, v_cnt_q};
      blank       = (h_ext >= H_VIS) || (v_ext >= V_VIS);
      HS          = !((h_ext >= HS_BEG) && (h_ext < HS_END));
      VS          = !((v_ext >= VS_BEG) && (v_ext < VS_END));
      col         = blank ? 10'd0 : h_cnt_q;
      row         = blank ? 9'd0 : v_cnt_q[8:0];
      frame_start = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
   end
endmodule

// File: tb/tb_vga_scan_gen.sv
// Directed bench: default build (line/wrap/reset), CLK_DIV=1 narrow-line build (full frame), CLK_DIV=1 default build.
module tb_vga_scan_gen;
   logic clk;
   logic r0, r1, r2;
   logic hs0, vs0, bl0, pt0, fs0;
   logic hs1, vs1, bl1, pt1, fs1;
   logic hs2, vs2, bl2, pt2, fs2;
   logic [8:0] row0, row1, row2;
   logic [9:0] col0, col1, col2;
   int checks = 0;
   int passed = 0;

   vga_scan_gen u0 (
      .clock(clk), .reset(r0), .HS(hs0), .VS(vs0), .blank(bl0), .row(row0), .col(col0),
      .pix_tick(pt0), .frame_start(fs0));

   // Narrow 24-pixel line keeps a full 525-line frame short enough to simulate.
   vga_scan_gen #(.CLK_DIV(1), .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2)) u1 (
      .clock(clk), .reset(r1), .HS(hs1), .VS(vs1), .blank(bl1), .row(row1), .col(col1),
      .pix_tick(pt1), .frame_start(fs1));

   vga_scan_gen #(.CLK_DIV(1)) u2 (
      .clock(clk), .reset(r2), .HS(hs2), .VS(vs2), .blank(bl2), .row(row2), .col(col2),
      .pix_tick(pt2), .frame_start(fs2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      r0 = 1'b1;
      repeat (3) tick();
      checks++; if (hs0 !== 1'b1) $display("FAIL rst_hs: got %0b want 1", hs0); else passed++;
      checks++; if (vs0 !== 1'b1) $display("FAIL rst_vs: got %0b want 1", vs0); else passed++;
      checks++; if (bl0 !== 1'b0) $display("FAIL rst_blank: got %0b want 0", bl0); else passed++;
      checks++; if (row0 !== 9'd0) $display("FAIL rst_row: got %0d want 0", row0); else passed++;
      checks++; if (col0 !== 10'd0) $display("FAIL rst_col: got %0d want 0", col0); else passed++;
      checks++; if (fs0 !== 1'b1) $display("FAIL rst_fs: got %0b want 1", fs0); else passed++;
      checks++; if (pt0 !== 1'b0) $display("FAIL rst_tick: got %0b want 0", pt0); else passed++;
      r0 = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         logic exp_pt;
         logic [9:0] exp_col;
         tick();
         exp_pt  = (k % 2 == 1);
         exp_col = 10'(k / 2);
         checks++; if (pt0 !== exp_pt) $display("FAIL rel_tick c%0d: got %0b want %0b", k, pt0, exp_pt); else passed++;
         checks++; if (col0 !== exp_col) $display("FAIL rel_col c%0d: got %0d want %0d", k, col0, exp_col); else passed++;
      end
   endtask

   task automatic test_line_timing();
      int col_err = 0, first_blank = -1, first_hs = -1, hs_low = 0, pt_cnt = 0, last_col = -1;
      r0 = 1'b1;
      tick();
      r0 = 1'b0;
      for (int k = 1; k <= 1600; k++) begin
         tick();
         if (pt0) pt_cnt++;
         if (k < 1600) begin
            if (!bl0) begin
               if (int'(col0) != k / 2) col_err++;
               last_col = int'(col0);
            end else if (first_blank < 0) first_blank = k;
            if (!hs0) begin
               hs_low++;
               if (first_hs < 0) first_hs = k;
            end
         end
      end
      checks++; if (col_err !== 0) $display("FAIL line_col_seq: got %0d bad cols want 0", col_err); else passed++;
      checks++; if (last_col !== 639) $display("FAIL line_last_col: got %0d want 639", last_col); else passed++;
      checks++; if (first_blank !== 1280) $display("FAIL line_blank_start: got clk %0d want 1280", first_blank); else passed++;
      checks++; if (first_hs !== 1312) $display("FAIL line_hs_start: got clk %0d want 1312", first_hs); else passed++;
      checks++; if (hs_low !== 192) $display("FAIL line_hs_width: got %0d clks want 192", hs_low); else passed++;
      checks++; if (pt_cnt !== 800) $display("FAIL line_ticks: got %0d want 800", pt_cnt); else passed++;
      checks++; if (row0 !== 9'd1) $display("FAIL line_next_row: got %0d want 1", row0); else passed++;
      checks++; if (col0 !== 10'd0) $display("FAIL line_next_col: got %0d want 0", col0); else passed++;
      checks++; if (bl0 !== 1'b0) $display("FAIL line_next_blank: got %0b want 0", bl0); else passed++;
   endtask

   // Continues from clock 1600 of test_line_timing (h=0, v=1).
   task automatic test_line_wrap();
      repeat (9599 - 1600) tick();
      checks++; if (bl0 !== 1'b1) $display("FAIL wrap_pre_blank: got %0b want 1", bl0); else passed++;
      checks++; if (pt0 !== 1'b1) $display("FAIL wrap_pre_tick: got %0b want 1", pt0); else passed++;
      checks++; if (hs0 !== 1'b1) $display("FAIL wrap_pre_hs: got %0b want 1", hs0); else passed++;
      tick();
      checks++; if (row0 !== 9'd6) $display("FAIL wrap_row: got %0d want 6", row0); else passed++;
      checks++; if (col0 !== 10'd0) $display("FAIL wrap_col: got %0d want 0", col0); else passed++;
      checks++; if (bl0 !== 1'b0) $display("FAIL wrap_blank: got %0b want 0", bl0); else passed++;
      checks++; if (fs0 !== 1'b0) $display("FAIL wrap_fs: got %0b want 0", fs0); else passed++;
   endtask

   task automatic test_midline_reset();
      repeat (834) tick();
      checks++; if (col0 !== 10'd417) $display("FAIL mid_pre_col: got %0d want 417", col0); else passed++;
      checks++; if (row0 !== 9'd6) $display("FAIL mid_pre_row: got %0d want 6", row0); else passed++;
      r0 = 1'b1;
      tick();
      checks++; if (col0 !== 10'd0) $display("FAIL mid_rst_col: got %0d want 0", col0); else passed++;
      checks++; if (row0 !== 9'd0) $display("FAIL mid_rst_row: got %0d want 0", row0); else passed++;
      checks++; if (fs0 !== 1'b1) $display("FAIL mid_rst_fs: got %0b want 1", fs0); else passed++;
      checks++; if (pt0 !== 1'b0) $display("FAIL mid_rst_tick: got %0b want 0", pt0); else passed++;
      tick();
      checks++; if (fs0 !== 1'b1) $display("FAIL mid_hold_fs: got %0b want 1", fs0); else passed++;
      checks++; if (col0 !== 10'd0) $display("FAIL mid_hold_col: got %0d want 0", col0); else passed++;
      r0 = 1'b0;
      tick();
      checks++; if (pt0 !== 1'b1) $display("FAIL mid_rel_tick: got %0b want 1", pt0); else passed++;
      tick();
      checks++; if (col0 !== 10'd1) $display("FAIL mid_rel_col: got %0d want 1", col0); else passed++;
   endtask

   task automatic test_frame(input bit mid);
      int vs_low = 0, first_vs = -1, hs_low = 0, vis = 0, late_vis = 0, fs_cnt = 0, max_row = 0;
      if (mid) begin
         repeat (300 * 24 + 9) tick();
         checks++; if (row1 !== 9'd300) $display("FAIL mf_pre_row: got %0d want 300", row1); else passed++;
         checks++; if (col1 !== 10'd9) $display("FAIL mf_pre_col: got %0d want 9", col1); else passed++;
      end
      r1 = 1'b1;
      tick();
      checks++; if (pt1 !== 1'b0) $display("FAIL fr_rst_tick m%0d: got %0b want 0", mid, pt1); else passed++;
      checks++; if (fs1 !== 1'b1) $display("FAIL fr_rst_fs m%0d: got %0b want 1", mid, fs1); else passed++;
      checks++; if (row1 !== 9'd0) $display("FAIL fr_rst_row m%0d: got %0d want 0", mid, row1); else passed++;
      checks++; if (col1 !== 10'd0) $display("FAIL fr_rst_col m%0d: got %0d want 0", mid, col1); else passed++;
      r1 = 1'b0;
      for (int k = 0; k < 12600; k++) begin
         if (!vs1) begin
            vs_low++;
            if (first_vs < 0) first_vs = k;
         end
         if (!hs1) hs_low++;
         if (!bl1) begin
            vis++;
            if (k >= 480 * 24) late_vis++;
            if (int'(row1) > max_row) max_row = int'(row1);
         end
         if (fs1) fs_cnt++;
         tick();
      end
      checks++; if (first_vs !== 11760) $display("FAIL fr_vs_start m%0d: got %0d want 11760", mid, first_vs); else passed++;
      checks++; if (vs_low !== 48) $display("FAIL fr_vs_width m%0d: got %0d want 48", mid, vs_low); else passed++;
      checks++; if (hs_low !== 2100) $display("FAIL fr_hs_total m%0d: got %0d want 2100", mid, hs_low); else passed++;
      checks++; if (vis !== 7680) $display("FAIL fr_visible m%0d: got %0d want 7680", mid, vis); else passed++;
      checks++; if (late_vis !== 0) $display("FAIL fr_vblank m%0d: got %0d want 0", mid, late_vis); else passed++;
      checks++; if (max_row !== 479) $display("FAIL fr_max_row m%0d: got %0d want 479", mid, max_row); else passed++;
      checks++; if (fs_cnt !== 1) $display("FAIL fr_fs_count m%0d: got %0d want 1", mid, fs_cnt); else passed++;
      checks++; if (fs1 !== 1'b1) $display("FAIL fr_wrap_fs m%0d: got %0b want 1", mid, fs1); else passed++;
      checks++; if (row1 !== 9'd0) $display("FAIL fr_wrap_row m%0d: got %0d want 0", mid, row1); else passed++;
      checks++; if (col1 !== 10'd0) $display("FAIL fr_wrap_col m%0d: got %0d want 0", mid, col1); else passed++;
   endtask

   task automatic test_clkdiv1();
      int pt_cnt = 0, hs_low = 0, first_hs = -1, first_blank = -1, vs_low = 0;
      r2 = 1'b1;
      tick();
      checks++; if (pt2 !== 1'b0) $display("FAIL d1_rst_tick: got %0b want 0", pt2); else passed++;
      r2 = 1'b0;
      #1;
      for (int k = 0; k < 800; k++) begin
         if (pt2) pt_cnt++;
         if (!vs2) vs_low++;
         if (!hs2) begin
            hs_low++;
            if (first_hs < 0) first_hs = k;
         end
         if (bl2 && first_blank < 0) first_blank = k;
         tick();
      end
      checks++; if (pt_cnt !== 800) $display("FAIL d1_ticks: got %0d want 800", pt_cnt); else passed++;
      checks++; if (first_hs !== 656) $display("FAIL d1_hs_start: got %0d want 656", first_hs); else passed++;
      checks++; if (hs_low !== 96) $display("FAIL d1_hs_width: got %0d want 96", hs_low); else passed++;
      checks++; if (first_blank !== 640) $display("FAIL d1_blank_start: got %0d want 640", first_blank); else passed++;
      checks++; if (vs_low !== 0) $display("FAIL d1_vs_line0: got %0d want 0", vs_low); else passed++;
      checks++; if (row2 !== 9'd1) $display("FAIL d1_next_row: got %0d want 1", row2); else passed++;
      checks++; if (col2 !== 10'd0) $display("FAIL d1_next_col: got %0d want 0", col2); else passed++;
   endtask

   initial begin
      r0 = 1'b1;
      r1 = 1'b1;
      r2 = 1'b1;
      tick();
      test_reset();
      test_line_timing();
      test_line_wrap();
      test_midline_reset();
      test_frame(1'b0);
      test_frame(1'b1);
      test_clkdiv1();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
